// File: rtl/add_round_key_stage.sv
// AddRoundKey stage for an iterative AES-128 encryption datapath.
// XORs each accepted state with the current round key. The key schedule
// advances by one step per accepted beat. A single output register gives
// full throughput under a valid/ready handshake.
module add_round_key_stage #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_load,
  input  logic [KW-1:0] cipher_key,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [KW-1:0] in_state,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [KW-1:0] out_state,
  output logic [3:0]    out_round,
  output logic          out_last
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  // FIPS-197 forward S-box. Entry x is stored at bits [8*(255-x) +: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [KW-1:0] r_key_store;
  logic [KW-1:0] r_rk;
  logic [3:0]    r_rnd;
  logic [7:0]    r_rcon;
  logic          r_key_valid;
  logic          r_out_valid;
  logic [KW-1:0] r_out_state;
  logic [3:0]    r_out_round;
  logic          r_out_last;

  logic          w_accept;
  logic [31:0]   w_rot;
  logic [31:0]   w_sub;
  logic [31:0]   w_t;
  logic [31:0]   w_n0, w_n1, w_n2, w_n3;
  logic [KW-1:0] w_rk_next;
  logic [7:0]    w_rcon_next;

  // A key_load cycle never accepts, so an upstream beat offered alongside it is held.
  assign in_ready = r_key_valid & ~key_load & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  // RotWord of w3: a cyclic left rotation by one byte.
  assign w_rot = {r_rk[23:0], r_rk[31:24]};

  // SubWord: four parallel S-box lookups, one per byte of the rotated word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign w_sub[31-8*gi -: 8] = SBOX[8*(255 - int'(w_rot[31-8*gi -: 8])) +: 8];
  end

  assign w_t         = w_sub ^ {r_rcon, 24'h000000};
  assign w_n0        = r_rk[127:96] ^ w_t;
  assign w_n1        = r_rk[95:64]  ^ w_n0;
  assign w_n2        = r_rk[63:32]  ^ w_n1;
  assign w_n3        = r_rk[31:0]   ^ w_n2;
  assign w_rk_next   = {w_n0, w_n1, w_n2, w_n3};
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  // Key schedule: the key load restarts it; each accept steps it or wraps it to round 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_store <= '0;
      r_rk        <= '0;
      r_rnd       <= 4'd0;
      r_rcon      <= 8'h01;
      r_key_valid <= 1'b0;
    end else if (key_load) begin
      r_key_store <= cipher_key;
      r_rk        <= cipher_key;
      r_rnd       <= 4'd0;
      r_rcon      <= 8'h01;
      r_key_valid <= 1'b1;
    end else if (w_accept) begin
      if (r_rnd == LAST_RND) begin
        r_rk   <= r_key_store;
        r_rnd  <= 4'd0;
        r_rcon <= 8'h01;
      end else begin
        r_rk   <= w_rk_next;
        r_rnd  <= r_rnd + 4'd1;
        r_rcon <= w_rcon_next;
      end
    end
  end

  // Output entry: load on accept, hold while stalled, and drop on key_load (abort).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_state <= '0;
      r_out_round <= 4'd0;
      r_out_last  <= 1'b0;
    end else if (key_load) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_state <= in_state ^ r_rk;
      r_out_round <= r_rnd;
      r_out_last  <= (r_rnd == LAST_RND);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_state = r_out_state;
  assign out_round = r_out_round;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage. It applies a table of FIPS-197 vectors, then
// stall, abort, reset and random sequences, all checked through a scoreboard.
module tb_add_round_key_stage;

  typedef struct packed {
    logic [127:0] s;
    logic [3:0]   r;
    logic         l;
  } exp_t;

  typedef struct packed {
    logic [127:0] in_state;
    logic [127:0] exp_state;
    logic [3:0]   exp_round;
    logic         exp_last;
  } vec_t;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk;
  logic         rst_n;
  logic         key_load;
  logic [127:0] cipher_key;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_last;

  add_round_key_stage #(.NR(10), .KW(128)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .cipher_key(cipher_key),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_round(out_round), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] rk [0:10];
  vec_t         vec [0:11];
  exp_t         q [$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         m_kv;
  logic         m_ov;
  int           m_rnd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive after the falling edge, check just after that, then update the model.
  task automatic cyc(input logic iv, input logic [127:0] st, input logic kl, input logic ordy,
                     input logic tbl, input vec_t v);
    logic exp_ir;
    logic acc;
    exp_t e;
    @(negedge clk);
    in_valid = iv; in_state = st; key_load = kl; cipher_key = KEY; out_ready = ordy;
    #1;
    exp_ir = m_kv & ~kl & (~m_ov | ordy);
    chk("in_ready", {127'd0, in_ready}, {127'd0, exp_ir});
    chk("out_valid", {127'd0, out_valid}, {127'd0, m_ov});
    if (m_ov && ordy) begin
      if (q.size() == 0) begin
        chk("queue_underflow", 128'd1, 128'd0);
      end else begin
        e = q.pop_front();
        chk("out_state", out_state, e.s);
        chk("out_round", {124'd0, out_round}, {124'd0, e.r});
        chk("out_last", {127'd0, out_last}, {127'd0, e.l});
        $display("xfer round=%0d state=%h last=%0d", out_round, out_state, out_last);
      end
    end
    acc = iv & exp_ir;
    if (kl) begin
      m_kv = 1'b1; m_rnd = 0; m_ov = 1'b0; q.delete();
    end else if (acc) begin
      if (tbl) begin
        e.s = v.exp_state; e.r = v.exp_round; e.l = v.exp_last;
      end else begin
        e.s = st ^ rk[m_rnd]; e.r = 4'(m_rnd); e.l = (m_rnd == 10);
      end
      q.push_back(e);
      m_rnd = (m_rnd == 10) ? 0 : m_rnd + 1;
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic reset_model();
    m_kv = 1'b0; m_ov = 1'b0; m_rnd = 0; q.delete();
  endtask

  initial begin
    vec_t         nv;
    logic [127:0] held_s;
    logic [3:0]   held_r;
    nv = '0;

    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    vec[0]  = '{128'h3243f6a8885a308d313198a2e0370734, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd0, 1'b0};
    vec[1]  = '{128'h046681e5e0cb199a48f8d37a2806264c, 128'ha49c7ff2689f352b6b5bea43026a5049, 4'd1, 1'b0};
    vec[2]  = '{128'h584dcaf11b4b5aacdbe7caa81b6bb0e5, 128'haa8f5f0361dde3ef82d24ad26832469a, 4'd2, 1'b0};
    vec[3]  = '{128'h0, 128'h3d80477d4716fe3e1e237e446d7a883b, 4'd3, 1'b0};
    vec[4]  = '{128'h0, 128'hef44a541a8525b7fb671253bdb0bad00, 4'd4, 1'b0};
    vec[5]  = '{128'h0, 128'hd4d1c6f87c839d87caf2b8bc11f915bc, 4'd5, 1'b0};
    vec[6]  = '{128'h0, 128'h6d88a37a110b3efddbf98641ca0093fd, 4'd6, 1'b0};
    vec[7]  = '{128'h0, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 4'd7, 1'b0};
    vec[8]  = '{128'h0, 128'head27321b58dbad2312bf5607f8d292f, 4'd8, 1'b0};
    vec[9]  = '{128'h0, 128'hac7766f319fadc2128d12941575c006e, 4'd9, 1'b0};
    vec[10] = '{128'h0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10, 1'b1};
    vec[11] = '{128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0, 1'b0};

    // Reset state.
    rst_n = 1'b0; key_load = 1'b0; cipher_key = '0; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_state", out_state, 128'd0);
    chk("rst_out_round", {124'd0, out_round}, 128'd0);
    chk("rst_out_last", {127'd0, out_last}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    rst_n = 1'b1;

    // No key loaded yet: a beat must not be accepted.
    cyc(1'b1, vec[0].in_state, 1'b0, 1'b1, 1'b0, nv);
    // key_load together with a valid beat: the beat is held.
    cyc(1'b1, vec[0].in_state, 1'b1, 1'b1, 1'b0, nv);

    // FIPS-197 table: rounds 0..10 and the wrap back to round 0.
    for (int i = 0; i < 12; i++) cyc(1'b1, vec[i].in_state, 1'b0, 1'b1, 1'b1, vec[i]);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, nv);

    // Stall: hold out_ready low for 5 cycles with in_valid high.
    cyc(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, 1'b0, nv);
    cyc(1'b1, 128'hffeeddccbbaa99887766554433221100, 1'b0, 1'b0, 1'b0, nv);
    held_s = out_state; held_r = out_round;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 128'hffeeddccbbaa99887766554433221100, 1'b0, 1'b0, 1'b0, nv);
      chk("stall_state", out_state, held_s);
      chk("stall_round", {124'd0, out_round}, {124'd0, held_r});
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 128'(i * 7919), 1'b0, 1'b1, 1'b0, nv);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, nv);

    // Abort: key_load while the round-4 output is pending.
    while (m_rnd != 4) cyc(1'b1, 128'h0, 1'b0, 1'b1, 1'b0, nv);
    cyc(1'b1, 128'h0123456789abcdef0123456789abcdef, 1'b0, 1'b0, 1'b0, nv);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, nv);
    cyc(1'b1, 128'h0, 1'b0, 1'b1, 1'b0, nv);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, nv);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, 1'b0,
          1'($urandom_range(0, 1)), 1'b0, nv);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, nv);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, nv);

    // Asynchronous reset in the middle of a block.
    for (int i = 0; i < 4; i++) cyc(1'b1, 128'h5a5a, 1'b0, 1'b1, 1'b0, nv);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("arst_out_state", out_state, 128'd0);
    chk("arst_out_round", {124'd0, out_round}, 128'd0);
    chk("arst_out_last", {127'd0, out_last}, 128'd0);
    chk("arst_in_ready", {127'd0, in_ready}, 128'd0);
    reset_model();
    cyc(1'b1, 128'h1, 1'b0, 1'b1, 1'b0, nv);
    rst_n = 1'b1;
    cyc(1'b1, 128'h1, 1'b0, 1'b1, 1'b0, nv);
    cyc(1'b1, 128'h1, 1'b0, 1'b1, 1'b0, nv);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, nv);
    for (int i = 0; i < 3; i++) cyc(1'b1, vec[i].in_state, 1'b0, 1'b1, 1'b1, vec[i]);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, nv);

    chk("queue_empty", 128'(q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
